// File: rtl/spi_register_target.sv
`timescale 1ns/1ps
// SPI target (CPOL=0, CPHA=0) serving 16-bit register frames:
// upper byte {rw, addr[6:0]}, lower byte write data / read data.
// Holds an 8-bit register file readable on-chip and over SPI.
module spi_register_target #(
    parameter int NUM_REGS     = 16,
    parameter int LOCAL_ADDR_W = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    SCLK,
    input  logic                    CS,
    input  logic                    MOSI,
    output logic                    MISO,
    output logic                    o_busy,
    output logic                    o_write_strobe,
    output logic [6:0]              o_write_addr,
    output logic [7:0]              o_write_data,
    output logic                    o_read_strobe,
    output logic                    o_frame_error,
    input  logic [LOCAL_ADDR_W-1:0] i_local_addr,
    output logic [7:0]              o_local_data
);

    localparam logic [7:0] LP_NUM_REGS = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [2:0]  r_sclk_sync;
    logic [2:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;
    logic [4:0]  r_bit_cnt;
    logic        r_overrun;
    logic [15:0] r_rx_shift;
    logic [7:0]  r_tx_shift;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic        r_miso;
    logic        r_busy;
    logic        r_write_strobe;
    logic [6:0]  r_write_addr;
    logic [7:0]  r_write_data;
    logic        r_read_strobe;
    logic        r_frame_error;
    logic [7:0]  r_local_data;
    logic [7:0]  r_regfile [NUM_REGS];

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_mosi;
    logic [6:0]  w_rx_addr;
    logic        w_rx_mapped;
    logic        w_lat_mapped;

    // Edge detection on synchroniser stage 2 vs stage 3
    always_comb begin
        w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
        w_sclk_fall  = ~r_sclk_sync[1] & r_sclk_sync[2];
        w_cs_fall    = ~r_cs_sync[1] & r_cs_sync[2];
        w_cs_rise    = r_cs_sync[1] & ~r_cs_sync[2];
        w_mosi       = r_mosi_sync[1];
        w_rx_addr    = {r_rx_shift[5:0], w_mosi};
        w_rx_mapped  = ({1'b0, w_rx_addr} < LP_NUM_REGS);
        w_lat_mapped = ({1'b0, r_addr} < LP_NUM_REGS);
    end

    // Pin synchronisers, preset to the idle bus (SCLK low, CS high)
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_cs_sync   <= {r_cs_sync[1:0], CS};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
            r_busy      <= ~r_cs_sync[1];
        end
    end

    // Frame state machine, shift registers, register file and strobes
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_overrun      <= 1'b0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_rw           <= 1'b0;
            r_addr         <= '0;
            r_miso         <= 1'b0;
            r_write_strobe <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
            r_read_strobe  <= 1'b0;
            r_frame_error  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regfile[i] <= '0;
            end
        end else begin
            r_write_strobe <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_frame_error  <= 1'b0;
            if (w_cs_fall) begin
                r_state    <= ST_ADDR;
                r_bit_cnt  <= '0;
                r_overrun  <= 1'b0;
                r_rx_shift <= '0;
                r_tx_shift <= '0;
                r_miso     <= 1'b0;
            end else if (w_cs_rise) begin
                // A CS rise with no SCLK activity is a glitch: no write, no error
                if (r_state != ST_IDLE) begin
                    if (r_bit_cnt == 5'd16 && !r_overrun) begin
                        if (!r_rw && w_lat_mapped) begin
                            r_regfile[r_addr[LOCAL_ADDR_W-1:0]] <= r_rx_shift[7:0];
                            r_write_addr   <= r_addr;
                            r_write_data   <= r_rx_shift[7:0];
                            r_write_strobe <= 1'b1;
                        end
                    end else if (r_bit_cnt != 5'd0) begin
                        r_frame_error <= 1'b1;
                    end
                end
                r_state <= ST_IDLE;
                r_miso  <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_sclk_rise) begin
                    if (r_bit_cnt == 5'd16) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_bit_cnt  <= r_bit_cnt + 5'd1;
                        r_rx_shift <= {r_rx_shift[14:0], w_mosi};
                        if (r_bit_cnt == 5'd7) begin
                            // Header complete: latch it and preload the read reply
                            r_state <= ST_DATA;
                            r_rw    <= r_rx_shift[6];
                            r_addr  <= w_rx_addr;
                            if (r_rx_shift[6]) begin
                                r_read_strobe <= 1'b1;
                                r_tx_shift    <= w_rx_mapped ?
                                    r_regfile[w_rx_addr[LOCAL_ADDR_W-1:0]] : 8'h00;
                            end else begin
                                r_tx_shift <= 8'h00;
                            end
                        end
                        if (r_bit_cnt == 5'd15) begin
                            r_state <= ST_DONE;
                        end
                    end
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt >= 5'd8 && r_bit_cnt <= 5'd15) begin
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    // On-chip read port with one cycle of latency
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_local_data <= '0;
        end else begin
            r_local_data <= r_regfile[i_local_addr];
        end
    end

    assign MISO           = r_miso;
    assign o_busy         = r_busy;
    assign o_write_strobe = r_write_strobe;
    assign o_write_addr   = r_write_addr;
    assign o_write_data   = r_write_data;
    assign o_read_strobe  = r_read_strobe;
    assign o_frame_error  = r_frame_error;
    assign o_local_data   = r_local_data;

endmodule

// File: tb/tb_spi_register_target.sv
`timescale 1ns/1ps
// Randomised bench for spi_register_target: an SPI master drives frames,
// a frame-level register model predicts strobes, errors and read replies.
module tb_spi_register_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       busy;
    logic       wstb;
    logic [6:0] waddr;
    logic [7:0] wdata;
    logic       rstb;
    logic       ferr;
    logic [3:0] laddr = 4'd0;
    logic [7:0] ldata;

    spi_register_target #(.NUM_REGS(16), .LOCAL_ADDR_W(4)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .SCLK(sclk), .CS(cs), .MOSI(mosi),
        .MISO(miso), .o_busy(busy), .o_write_strobe(wstb), .o_write_addr(waddr),
        .o_write_data(wdata), .o_read_strobe(rstb), .o_frame_error(ferr),
        .i_local_addr(laddr), .o_local_data(ldata)
    );

    always #10 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] m_regs [16];
    logic [6:0] m_waddr;
    logic [7:0] m_wdata;
    int         ws_cnt = 0;
    int         rs_cnt = 0;
    int         fe_cnt = 0;
    logic [6:0] ws_addr;
    logic [7:0] ws_data;
    bit         quiet = 1'b0;
    bit         prev_ok = 1'b0;
    logic [3:0] prev_addr = 4'd0;
    int         half = 6;
    logic [15:0] rx_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Master side of one frame; optionally resets the target after rst_after bits
    task automatic send_frame(input logic [15:0] word, input int nbits, input int rst_after,
                              output logic [15:0] miso_word, output bit did_reset);
        logic [15:0] tmp;
        miso_word = '0;
        did_reset = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        mosi = word[15];
        for (int b = 0; b < nbits; b++) begin
            tmp = word << b;
            mosi = (b < 16) ? tmp[15] : 1'b0;
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            if (b < 16) miso_word = {miso_word[14:0], miso};
            if (b == 0) check("busy_in_frame", 32'(busy), 32'd1);
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            if (b + 1 == rst_after) begin
                @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("rst_miso", 32'(miso), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_ldata", 32'(ldata), 32'd0);
                check("rst_waddr", 32'(waddr), 32'd0);
                cs = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                did_reset = 1'b1;
                return;
            end
        end
        repeat (half) @(negedge clk);
        cs = 1'b1;
    endtask

    // One frame checked against the register model
    task automatic run_frame(input logic [15:0] word, input int nbits, input int rst_after,
                             output logic [15:0] miso_word);
        bit rw, mapped, did_reset, exp_ws, exp_rs, exp_fe;
        logic [6:0]  addr;
        logic [15:0] exp_miso;
        int ws0, rs0, fe0;
        quiet = 1'b0;
        rw = word[15];
        addr = word[14:8];
        mapped = (addr < 7'd16);
        exp_ws = (nbits == 16) && !rw && mapped;
        exp_rs = (nbits >= 8) && rw;
        exp_fe = (nbits != 0) && (nbits != 16);
        exp_miso = {8'h00, (rw && mapped) ? m_regs[addr[3:0]] : 8'h00};
        ws0 = ws_cnt; rs0 = rs_cnt; fe0 = fe_cnt;
        half = $urandom_range(5, 8);
        send_frame(word, nbits, rst_after, miso_word, did_reset);
        if (did_reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_waddr = '0;
            m_wdata = '0;
            exp_ws = 1'b0;
            exp_fe = 1'b0;
            exp_rs = (rst_after >= 8) && rw;
        end
        repeat (12) @(negedge clk);
        check("write_strobes", 32'(ws_cnt - ws0), 32'(exp_ws));
        check("read_strobes", 32'(rs_cnt - rs0), 32'(exp_rs));
        check("frame_errors", 32'(fe_cnt - fe0), 32'(exp_fe));
        if (exp_ws) begin
            check("strobe_addr", 32'(ws_addr), 32'(addr));
            check("strobe_data", 32'(ws_data), 32'(word[7:0]));
            m_regs[addr[3:0]] = word[7:0];
            m_waddr = addr;
            m_wdata = word[7:0];
        end
        if (nbits == 16 && rw && !did_reset) check("miso_word", 32'(miso_word), 32'(exp_miso));
        check("held_waddr", 32'(waddr), 32'(m_waddr));
        check("held_wdata", 32'(wdata), 32'(m_wdata));
        check("idle_busy", 32'(busy), 32'd0);
        quiet = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_waddr = '0;
        m_wdata = '0;

        // Per-cycle monitor: strobe counting and on-chip read port checking
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (wstb) begin ws_cnt++; ws_addr = waddr; ws_data = wdata; end
                    if (rstb) rs_cnt++;
                    if (ferr) fe_cnt++;
                end
                if (quiet && prev_ok) begin
                    check("local_data", 32'(ldata), 32'(m_regs[prev_addr]));
                    check("idle_miso", 32'(miso), 32'd0);
                end
                prev_addr = 4'($urandom_range(0, 15));
                laddr = prev_addr;
                prev_ok = quiet && rst_n;
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wstb", 32'(wstb), 32'd0);
        check("reset_ferr", 32'(ferr), 32'd0);
        check("reset_wdata", 32'(wdata), 32'd0);
        check("reset_ldata", 32'(ldata), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        quiet = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(16'h05A5, 16, -1, rx_word);
        check("t1_addr", 32'(ws_addr), 32'h05);
        check("t1_data", 32'(ws_data), 32'hA5);
        run_frame(16'h8500, 16, -1, rx_word);
        check("t2_miso", 32'(rx_word), 32'h00A5);
        run_frame(16'h0377, 12, -1, rx_word);
        run_frame(16'h7F11, 16, -1, rx_word);
        run_frame(16'hFF00, 16, -1, rx_word);
        check("t4_miso", 32'(rx_word), 32'h0000);
        run_frame(16'h0233, 17, -1, rx_word);
        run_frame(16'h0C5E, 16, -1, rx_word);
        run_frame(16'h0999, 16, 10, rx_word);
        run_frame(16'h0142, 16, -1, rx_word);
        check("t6_addr", 32'(ws_addr), 32'h01);
        check("t6_data", 32'(ws_data), 32'h42);
        run_frame(16'h8100, 16, -1, rx_word);
        check("t6_readback", 32'(rx_word), 32'h0042);
        run_frame(16'h0000, 0, -1, rx_word);

        for (int f = 0; f < 40; f++) begin
            logic [15:0] w;
            int nb;
            w[15] = 1'($urandom_range(0, 1));
            w[14:8] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 19));
            w[7:0] = 8'($urandom);
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : 16;
            run_frame(w, nb, -1, rx_word);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
